rumble_sense: RTL and testbench

RUMBLE_SENSE -- requirements
Module: rumble_sense

---
 rtl/rumble_pkg.sv | 21 ++
 rtl/rumble_sense_if.sv | 19 +
 rtl/rumble_sense_pin_filter.sv | 53 +++++
 rtl/rumble_sense.sv | 152 +++++++++++++++
 tb/tb_rumble_sense.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rumble_pkg.sv
// Shared definitions for the rumble motor blocks: state encoding and parameter defaults.
package rumble_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned GLITCH_CYCLES_DEF  = 4;
  localparam int unsigned ARM_EDGES_DEF      = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned EDGE_COUNT_W       = 16;

  // Bits needed to hold every value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rumble_sense_if.sv
// Cartridge-pin bundle seen by the rumble sensor: sensed pins in, direction and status out.
interface rumble_sense_if;
  logic [7:4] cart_tran_bank0;
  logic [7:0] cart_tran_bank3;
  logic       cart_tran_bank0_dir;
  logic       cart_tran_bank3_dir;
  logic       active;
  logic [15:0] edge_count;

  modport master (
    output cart_tran_bank0, cart_tran_bank3,
    input  cart_tran_bank0_dir, cart_tran_bank3_dir, active, edge_count
  );

  modport slave (
    input  cart_tran_bank0, cart_tran_bank3,
    output cart_tran_bank0_dir, cart_tran_bank3_dir, active, edge_count
  );
endinterface

// File: rtl/rumble_sense_pin_filter.sv
// Synchroniser chain followed by a consecutive-sample glitch filter for one sensed pin.
module pin_filter
  import rumble_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF,
  parameter logic        RESET_LEVEL   = 1'b0
)(
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level
);

  localparam int unsigned      CNT_W    = cnt_width(GLITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign o_level  = r_level;

  // Shift the raw pin through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync[0] <= i_pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Count consecutive samples that disagree with the filtered level; adopt them once enough accrue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else if (w_sample == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_sample;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rumble_sense.sv
// Rumble motor activity sensor: filters the enable/drive pins, qualifies drive edges and tracks activity.
module rumble_sense
  import rumble_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned GLITCH_CYCLES  = GLITCH_CYCLES_DEF,
  parameter int unsigned ARM_EDGES      = ARM_EDGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
  input logic           clk_74a,
  input logic           reset,
  rumble_sense_if.slave cart_if
);

  localparam int unsigned      ARM_W    = cnt_width(ARM_EDGES);
  localparam int unsigned      TMR_W    = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_EDGES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ARM_W-1:0]        r_arm_cnt;
  logic [ARM_W-1:0]        w_arm_nxt;
  logic [TMR_W-1:0]        r_timer;
  logic [TMR_W-1:0]        w_timer_nxt;
  logic                    r_active;
  logic [EDGE_COUNT_W-1:0] r_edge_count;
  logic                    r_drv_d;
  logic                    w_en_level;
  logic                    w_drv_level;
  logic                    w_enable;
  logic                    w_drive_edge;
  logic                    w_timeout;
  logic                    w_unused_pins;

  pin_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .GLITCH_CYCLES (GLITCH_CYCLES),
    .RESET_LEVEL   (1'b1)
  ) u_en_filt (
    .clk     (clk_74a),
    .rst     (reset),
    .i_pin   (cart_if.cart_tran_bank0[6]),
    .o_level (w_en_level)
  );

  pin_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .GLITCH_CYCLES (GLITCH_CYCLES),
    .RESET_LEVEL   (1'b0)
  ) u_drv_filt (
    .clk     (clk_74a),
    .rst     (reset),
    .i_pin   (cart_if.cart_tran_bank3[1]),
    .o_level (w_drv_level)
  );

  assign w_unused_pins = ^{cart_if.cart_tran_bank0[7], cart_if.cart_tran_bank0[5:4],
                           cart_if.cart_tran_bank3[7:2], cart_if.cart_tran_bank3[0]};

  assign w_enable     = ~w_en_level;
  assign w_drive_edge = w_drv_level ^ r_drv_d;
  assign w_timeout    = (r_timer == TMR_LAST);

  // State, arm counter, timer and registered activity flag.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_arm_cnt <= '0;
      r_timer   <= '0;
      r_active  <= 1'b0;
      r_drv_d   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm_cnt <= w_arm_nxt;
      r_timer   <= w_timer_nxt;
      r_active  <= (w_state_nxt == ST_ACTIVE);
      r_drv_d   <= w_drv_level;
    end
  end

  // Qualified drive edges counted in any state, saturating.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      r_edge_count <= '0;
    end else if (w_drive_edge && w_enable && (r_edge_count != '1)) begin
      r_edge_count <= r_edge_count + 1'b1;
    end
  end

  // Next-state logic; edges beat timeouts, a dropped enable beats everything.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_nxt   = r_arm_cnt;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        w_arm_nxt   = '0;
        w_timer_nxt = '0;
        if (w_drive_edge) begin
          w_arm_nxt   = ARM_W'(1);
          w_state_nxt = (ARM_EDGES <= 1) ? ST_ACTIVE : ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (w_drive_edge) begin
          w_arm_nxt   = r_arm_cnt + 1'b1;
          w_timer_nxt = '0;
          if ((r_arm_cnt + 1'b1) == ARM_LAST) begin
            w_state_nxt = ST_ACTIVE;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_arm_nxt   = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_drive_edge) begin
          w_timer_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_arm_nxt   = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_arm_nxt   = '0;
        w_timer_nxt = '0;
      end
    endcase
    if (!w_enable) begin
      w_state_nxt = ST_IDLE;
      w_arm_nxt   = '0;
      w_timer_nxt = '0;
    end
  end

  // Drive the interface outputs; both pin banks are inputs only.
  always_comb begin
    cart_if.cart_tran_bank0_dir = 1'b0;
    cart_if.cart_tran_bank3_dir = 1'b0;
    cart_if.active              = r_active;
    cart_if.edge_count          = r_edge_count;
  end

endmodule

// File: tb/tb_rumble_sense.sv
// Self-checking bench for rumble_sense: directed scenarios plus random pin activity against a cycle model.
module tb_rumble_sense;
  import rumble_pkg::*;

  localparam int S = int'(SYNC_STAGES_DEF);
  localparam int G = int'(GLITCH_CYCLES_DEF);
  localparam int A = int'(ARM_EDGES_DEF);
  localparam int T = int'(TIMEOUT_CYCLES_DEF);
  localparam int HIST = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rumble_sense_if cart_if();

  rumble_sense #(
    .SYNC_STAGES    (S),
    .GLITCH_CYCLES  (G),
    .ARM_EDGES      (A),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_74a (clk),
    .reset   (rst),
    .cart_if (cart_if.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Raw pin levels the bench drives (bank0[6] is active-low enable).
  bit p_en  = 1'b1;
  bit p_drv = 1'b0;

  // Model: raw history since reset, filtered levels, pending edge, activity bookkeeping.
  bit raw_hist [2][0:HIST-1];
  int c;
  bit lv [2];
  bit pend;
  bit m_eng;
  bit m_act;
  int m_arms;
  int m_timer;
  int unsigned m_count;
  int since_edge;

  // Synchronised sample seen by the filter at edge k after reset.
  function automatic bit samp(input int p, input int k);
    if (k < S) return (p == 0);
    return raw_hist[p][k - S];
  endfunction

  // Level flips when the last G samples all agree and differ from it.
  function automatic bit window_flips(input int p, input int k, input bit lvl);
    bit v;
    if (k < G - 1) return 1'b0;
    v = samp(p, k);
    if (v == lvl) return 1'b0;
    for (int i = 1; i < G; i++) begin
      if (samp(p, k - i) != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    c = 0; lv[0] = 1'b1; lv[1] = 1'b0; pend = 1'b0;
    m_eng = 1'b0; m_act = 1'b0; m_arms = 0; m_timer = 0; m_count = 0;
    since_edge = 0;
  endtask

  task automatic model_step();
    bit en, e, old;
    en = !lv[0];
    e  = pend;
    if (e && en) since_edge = 0; else since_edge++;
    if (e && en && m_count != 32'hFFFF) m_count++;
    if (!en) begin
      m_eng = 1'b0; m_act = 1'b0; m_arms = 0; m_timer = 0;
    end else if (!m_eng) begin
      if (e) begin
        m_eng = 1'b1; m_arms = 1; m_timer = 0; m_act = (A == 1);
      end
    end else if (e) begin
      m_timer = 0;
      if (!m_act) begin
        m_arms++;
        if (m_arms == A) m_act = 1'b1;
      end
    end else if (m_timer == T - 1) begin
      m_eng = 1'b0; m_act = 1'b0; m_arms = 0; m_timer = 0;
    end else begin
      m_timer++;
    end
    raw_hist[0][c] = p_en;
    raw_hist[1][c] = p_drv;
    old = lv[1];
    for (int p = 0; p < 2; p++) begin
      if (window_flips(p, c, lv[p])) lv[p] = !lv[p];
    end
    pend = (lv[1] != old);
    if (c < HIST - 1) c++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_pins();
    logic [7:4] b0;
    logic [7:0] b3;
    b0    = 4'($urandom);
    b0[6] = p_en;
    b3    = 8'($urandom);
    b3[1] = p_drv;
    cart_if.cart_tran_bank0 = b0;
    cart_if.cart_tran_bank3 = b3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pins();
      @(posedge clk);
      cyc++;
      if (rst) model_reset(); else model_step();
      #1;
      chk("active", {31'd0, cart_if.active}, {31'd0, m_act});
      chk("edge_count", {16'd0, cart_if.edge_count}, m_count);
    end
  endtask

  task automatic toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      p_drv = !p_drv;
      ticks(gap);
    end
  endtask

  initial begin
    int waited;
    model_reset();
    rst = 1'b1; p_en = 1'b1; p_drv = 1'b0;
    ticks(3);
    chk("rst_active", {31'd0, cart_if.active}, 32'd0);
    chk("rst_edge_count", {16'd0, cart_if.edge_count}, 32'd0);
    chk("bank0_dir", {31'd0, cart_if.cart_tran_bank0_dir}, 32'd0);
    chk("bank3_dir", {31'd0, cart_if.cart_tran_bank3_dir}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // Disabled motor: toggling is ignored.
    toggles(100, 8);
    chk("dis_active", {31'd0, cart_if.active}, 32'd0);
    chk("dis_count", {16'd0, cart_if.edge_count}, 32'd0);

    // Enable and arm: three edges are not enough, the fourth activates.
    p_en = 1'b0;
    ticks(10);
    toggles(3, 8);
    chk("arm3_active", {31'd0, cart_if.active}, 32'd0);
    chk("arm3_count", {16'd0, cart_if.edge_count}, 32'd3);
    toggles(1, 8);
    chk("arm4_active", {31'd0, cart_if.active}, 32'd1);
    chk("arm4_count", {16'd0, cart_if.edge_count}, 32'd4);

    // Stop toggling: activity drops TIMEOUT cycles after the last edge.
    waited = 0;
    while (cart_if.active === 1'b1 && waited < T + 100) begin
      ticks(1);
      waited++;
    end
    chk("timeout_drop", {31'd0, cart_if.active}, 32'd0);
    chk("timeout_len", since_edge, T);

    // Short glitches never qualify as edges.
    rst = 1'b1; ticks(1); rst = 1'b0;
    p_en = 1'b0;
    ticks(10);
    for (int k = 0; k < 10; k++) begin
      p_drv = 1'b1; ticks(2);
      p_drv = 1'b0; ticks(18);
    end
    chk("glitch_active", {31'd0, cart_if.active}, 32'd0);
    chk("glitch_count", {16'd0, cart_if.edge_count}, 32'd0);

    // Drop enable while arming, then re-arm from scratch.
    toggles(2, 8);
    chk("arm2_count", {16'd0, cart_if.edge_count}, 32'd2);
    p_en = 1'b1;
    ticks(10);
    chk("disarm_active", {31'd0, cart_if.active}, 32'd0);
    p_en = 1'b0;
    ticks(10);
    toggles(4, 8);
    chk("rearm_active", {31'd0, cart_if.active}, 32'd1);
    chk("rearm_count", {16'd0, cart_if.edge_count}, 32'd6);

    // Reset in the middle of activity.
    rst = 1'b1; ticks(1);
    chk("rst_mid_active", {31'd0, cart_if.active}, 32'd0);
    chk("rst_mid_count", {16'd0, cart_if.edge_count}, 32'd0);
    rst = 1'b0;

    // Saturation of the edge counter.
    p_en = 1'b0;
    ticks(10);
    force dut.r_edge_count = 16'hFFFE;
    m_count = 32'hFFFE;
    ticks(1);
    release dut.r_edge_count;
    ticks(2);
    toggles(3, 8);
    chk("sat_count", {16'd0, cart_if.edge_count}, 32'h0000FFFF);

    // Random pin activity with quiet stretches long enough to time out.
    for (int blk = 0; blk < 3; blk++) begin
      if (blk == 1) begin
        rst = 1'b1; ticks(2); rst = 1'b0;
      end
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 15) == 0) p_en = !p_en;
        p_drv = !p_drv;
        ticks($urandom_range(1, 12));
      end
      p_en = 1'b0;
      ticks(T + 60);
    end

    chk("end_bank0_dir", {31'd0, cart_if.cart_tran_bank0_dir}, 32'd0);
    chk("end_bank3_dir", {31'd0, cart_if.cart_tran_bank3_dir}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
